reg_write_queue: RTL and testbench

Writer-side front end for the 8x16 register file write port (regWrite / regWriteNum / writeData). It accepts writeback requests from two producers, the ALU path and the memory/load path, and buffers them in a small FIFO. It retires at most one request per cycle into the register file and drops writes to r0 before they reach the file. It also exposes a lookup of still-pending writes so the read side can forward the youngest queued value.

---
 rtl/reg_write_queue_if.sv | 35 +++
 rtl/reg_write_queue.sv | 172 +++++++++++++++++
 tb/tb_reg_write_queue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_queue_if.sv
// Bundles the two producer handshakes and the register file write port
// for the writeback queue. The queue is the slave; producers and the
// register file side together form the master.
interface reg_write_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_num;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_num;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              regWrite;
    logic [ADDR_W-1:0] regWriteNum;
    logic [DATA_W-1:0] writeData;

    modport slave (
        input  mem_valid, mem_num, mem_data,
        input  alu_valid, alu_num, alu_data,
        output mem_ready, alu_ready,
        output regWrite, regWriteNum, writeData
    );

    modport master (
        output mem_valid, mem_num, mem_data,
        output alu_valid, alu_num, alu_data,
        input  mem_ready, alu_ready,
        input  regWrite, regWriteNum, writeData
    );
endinterface

// File: rtl/reg_write_queue.sv
// Writeback queue in front of the 8x16 register file write port.
// Two producers (memory/load path and ALU path) push {num, data} entries
// into a small circular FIFO; one entry retires per cycle unless held.
// Writes to r0 are swallowed at the input and flagged with a pulse.
// Pending entries can be searched so the read side can forward the
// youngest queued value for a register.
module reg_write_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    reg_write_queue_if.slave         bus,
    input  logic [ADDR_W-1:0]        chk_num1,
    output logic                     chk_hit1,
    output logic [DATA_W-1:0]        chk_data1,
    input  logic [ADDR_W-1:0]        chk_num2,
    output logic                     chk_hit2,
    output logic [DATA_W-1:0]        chk_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped_r0
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] LVL_ONE_FREE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LVL_TWO_FREE = CNT_W'(DEPTH - 2);

    // Entry storage; contents are don't-care until written, so no reset.
    logic [ADDR_W-1:0] r_numMem  [DEPTH];
    logic [DATA_W-1:0] r_dataMem [DEPTH];

    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_dropped;

    logic              w_memReady;
    logic              w_aluReady;
    logic              w_memXfer;
    logic              w_aluXfer;
    logic              w_memEnq;
    logic              w_aluEnq;
    logic              w_memIsR0;
    logic              w_aluIsR0;
    logic              w_pop;
    logic [PTR_W-1:0]  w_aluSlot;
    logic [PTR_W-1:0]  w_wrPtrNext;
    logic [CNT_W-1:0]  w_countNext;

    logic [PTR_W-1:0]  w_slotIdx  [DEPTH];
    logic              w_slotLive [DEPTH];

    logic              w_hit1;
    logic [DATA_W-1:0] w_data1;
    logic              w_hit2;
    logic [DATA_W-1:0] w_data2;

    // Readiness looks only at the registered occupancy. The ALU path must
    // leave room for a simultaneous memory request, which is older and
    // therefore takes the first free slot.
    always_comb begin
        w_memReady = (r_count <= LVL_ONE_FREE);
        if (bus.mem_valid) begin
            w_aluReady = (r_count <= LVL_TWO_FREE);
        end else begin
            w_aluReady = (r_count <= LVL_ONE_FREE);
        end
    end

    // Handshake decode: an accepted r0 request is consumed without taking
    // a slot, so only non-r0 transfers become enqueues.
    always_comb begin
        w_memIsR0   = (bus.mem_num == '0);
        w_aluIsR0   = (bus.alu_num == '0);
        w_memXfer   = bus.mem_valid && w_memReady;
        w_aluXfer   = bus.alu_valid && w_aluReady;
        w_memEnq    = w_memXfer && !w_memIsR0;
        w_aluEnq    = w_aluXfer && !w_aluIsR0;
        w_pop       = (r_count != '0) && !hold;
        w_aluSlot   = r_wrPtr + PTR_W'(w_memEnq);
        w_wrPtrNext = r_wrPtr + PTR_W'(w_memEnq) + PTR_W'(w_aluEnq);
        w_countNext = r_count + CNT_W'(w_memEnq) + CNT_W'(w_aluEnq)
                    - CNT_W'(w_pop);
    end

    // Write accepted entries; the mem entry lands first, the alu entry
    // directly behind it when both arrive together.
    always_ff @(posedge clk) begin
        if (w_memEnq) begin
            r_numMem[r_wrPtr]  <= bus.mem_num;
            r_dataMem[r_wrPtr] <= bus.mem_data;
        end
        if (w_aluEnq) begin
            r_numMem[w_aluSlot]  <= bus.alu_num;
            r_dataMem[w_aluSlot] <= bus.alu_data;
        end
    end

    // Pointer, occupancy and r0-drop pulse bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_wrPtr   <= w_wrPtrNext;
            r_rdPtr   <= r_rdPtr + PTR_W'(w_pop);
            r_count   <= w_countNext;
            r_dropped <= (w_memXfer && w_memIsR0) || (w_aluXfer && w_aluIsR0);
        end
    end

    // Map each age position (0 = oldest) to its physical slot and mark
    // which positions currently hold a queued entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_slotIdx[i]  = r_rdPtr + PTR_W'(i);
            w_slotLive[i] = (CNT_W'(i) < r_count);
        end
    end

    // Forwarding search, walking oldest to youngest so the last match
    // seen is the youngest pending value. r0 never hits.
    always_comb begin
        w_hit1  = 1'b0;
        w_data1 = '0;
        w_hit2  = 1'b0;
        w_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slotLive[i] && (chk_num1 != '0) &&
                (r_numMem[w_slotIdx[i]] == chk_num1)) begin
                w_hit1  = 1'b1;
                w_data1 = r_dataMem[w_slotIdx[i]];
            end
            if (w_slotLive[i] && (chk_num2 != '0) &&
                (r_numMem[w_slotIdx[i]] == chk_num2)) begin
                w_hit2  = 1'b1;
                w_data2 = r_dataMem[w_slotIdx[i]];
            end
        end
    end

    // Retire port: the head entry is presented whenever the queue is not
    // empty; the address and data read as zero when there is nothing queued.
    always_comb begin
        bus.regWrite    = w_pop;
        bus.regWriteNum = '0;
        bus.writeData   = '0;
        if (r_count != '0) begin
            bus.regWriteNum = r_numMem[r_rdPtr];
            bus.writeData   = r_dataMem[r_rdPtr];
        end
    end

    // Remaining output connections.
    always_comb begin
        bus.mem_ready = w_memReady;
        bus.alu_ready = w_aluReady;
        chk_hit1      = w_hit1;
        chk_data1     = w_data1;
        chk_hit2      = w_hit2;
        chk_data2     = w_data2;
        count         = r_count;
        dropped_r0    = r_dropped;
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue: each scenario task drives the
// inputs and compares outputs against hand-computed values.
module tb_reg_write_queue;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [2:0]  chk_num1;
    logic        chk_hit1;
    logic [15:0] chk_data1;
    logic [2:0]  chk_num2;
    logic        chk_hit2;
    logic [15:0] chk_data2;
    logic [2:0]  count;
    logic        dropped_r0;

    int checks;
    int errors;

    reg_write_queue_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg_write_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .bus        (bus.slave),
        .chk_num1   (chk_num1),
        .chk_hit1   (chk_hit1),
        .chk_data1  (chk_data1),
        .chk_num2   (chk_num2),
        .chk_hit2   (chk_hit2),
        .chk_data2  (chk_data2),
        .count      (count),
        .dropped_r0 (dropped_r0)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs change.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.mem_valid = 1'b0;
        bus.mem_num   = 3'd0;
        bus.mem_data  = 16'h0;
        bus.alu_valid = 1'b0;
        bus.alu_num   = 3'd0;
        bus.alu_data  = 16'h0;
    endtask

    task automatic driveMem(input logic [2:0] n, input logic [15:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_num   = n;
        bus.mem_data  = d;
    endtask

    task automatic driveAlu(input logic [2:0] n, input logic [15:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_num   = n;
        bus.alu_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        chk_num1 = 3'd0;
        chk_num2 = 3'd0;
        clearInputs();
        @(negedge clk);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d expected=0", count); end
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL reset_we actual=%0b expected=0", bus.regWrite); end
        checks++; if (dropped_r0 !== 1'b0) begin errors++; $display("FAIL reset_drop actual=%0b expected=0", dropped_r0); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready actual=%0b expected=1", bus.mem_ready); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready actual=%0b expected=1", bus.alu_ready); end
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        driveAlu(3'd3, 16'h1234);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (bus.regWrite !== 1'b1) begin errors++; $display("FAIL single_we actual=%0b expected=1", bus.regWrite); end
        checks++; if (bus.regWriteNum !== 3'd3) begin errors++; $display("FAIL single_num actual=%0d expected=3", bus.regWriteNum); end
        checks++; if (bus.writeData !== 16'h1234) begin errors++; $display("FAIL single_data actual=%0h expected=1234", bus.writeData); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count actual=%0d expected=1", count); end
        cycle();
        @(negedge clk);
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL single_we_after actual=%0b expected=0", bus.regWrite); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after actual=%0d expected=0", count); end
        checks++; if (bus.writeData !== 16'h0) begin errors++; $display("FAIL single_empty_data actual=%0h expected=0", bus.writeData); end
        cycle();
    endtask

    task automatic test_dual();
        driveMem(3'd2, 16'hAAAA);
        driveAlu(3'd5, 16'h5555);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL dual_count0 actual=%0d expected=2", count); end
        checks++; if (bus.regWrite !== 1'b1 || bus.regWriteNum !== 3'd2 || bus.writeData !== 16'hAAAA) begin errors++; $display("FAIL dual_first actual=%0b/%0d/%0h expected=1/2/aaaa", bus.regWrite, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dual_count1 actual=%0d expected=1", count); end
        checks++; if (bus.regWrite !== 1'b1 || bus.regWriteNum !== 3'd5 || bus.writeData !== 16'h5555) begin errors++; $display("FAIL dual_second actual=%0b/%0d/%0h expected=1/5/5555", bus.regWrite, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (count !== 3'd0 || bus.regWrite !== 1'b0) begin errors++; $display("FAIL dual_drain actual=%0d/%0b expected=0/0", count, bus.regWrite); end
        cycle();
    endtask

    task automatic test_full_hold();
        hold = 1'b1;
        driveMem(3'd1, 16'h0101);
        driveAlu(3'd2, 16'h0202);
        cycle();
        driveMem(3'd3, 16'h0303);
        driveAlu(3'd4, 16'h0404);
        @(negedge clk);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL full_count2 actual=%0d expected=2", count); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL full_alu_ready2 actual=%0b expected=1", bus.alu_ready); end
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL full_hold_we actual=%0b expected=0", bus.regWrite); end
        cycle();
        driveMem(3'd5, 16'h0505);
        driveAlu(3'd6, 16'h0606);
        @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count4 actual=%0d expected=4", count); end
        checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_ready actual=%0b/%0b expected=0/0", bus.mem_ready, bus.alu_ready); end
        cycle();
        hold = 1'b0;
        bus.alu_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_stays4 actual=%0d expected=4", count); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_slot actual=%0b expected=0", bus.mem_ready); end
        checks++; if (bus.regWrite !== 1'b1 || bus.regWriteNum !== 3'd1 || bus.writeData !== 16'h0101) begin errors++; $display("FAIL full_w1 actual=%0b/%0d/%0h expected=1/1/0101", bus.regWrite, bus.regWriteNum, bus.writeData); end
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (count !== 3'd3 || bus.regWriteNum !== 3'd2 || bus.writeData !== 16'h0202) begin errors++; $display("FAIL full_w2 actual=%0d/%0d/%0h expected=3/2/0202", count, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (count !== 3'd2 || bus.regWriteNum !== 3'd3 || bus.writeData !== 16'h0303) begin errors++; $display("FAIL full_w3 actual=%0d/%0d/%0h expected=2/3/0303", count, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (count !== 3'd1 || bus.regWriteNum !== 3'd4 || bus.writeData !== 16'h0404) begin errors++; $display("FAIL full_w4 actual=%0d/%0d/%0h expected=1/4/0404", count, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (count !== 3'd0 || bus.regWrite !== 1'b0) begin errors++; $display("FAIL full_drain actual=%0d/%0b expected=0/0", count, bus.regWrite); end
        cycle();
    endtask

    task automatic test_r0();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b0) begin errors++; $display("FAIL r0_idle actual=%0b expected=0", dropped_r0); end
        cycle();
        driveAlu(3'd0, 16'hFFFF);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b1) begin errors++; $display("FAIL r0_pulse1 actual=%0b expected=1", dropped_r0); end
        checks++; if (bus.regWrite !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL r0_no_write actual=%0b/%0d expected=0/0", bus.regWrite, count); end
        cycle();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b0) begin errors++; $display("FAIL r0_pulse1_end actual=%0b expected=0", dropped_r0); end
        cycle();
        driveMem(3'd0, 16'h1111);
        driveAlu(3'd1, 16'h0007);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b1) begin errors++; $display("FAIL r0_pulse2 actual=%0b expected=1", dropped_r0); end
        checks++; if (count !== 3'd1 || bus.regWrite !== 1'b1 || bus.regWriteNum !== 3'd1 || bus.writeData !== 16'h0007) begin errors++; $display("FAIL r0_mixed actual=%0d/%0b/%0d/%0h expected=1/1/1/0007", count, bus.regWrite, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL r0_mixed_end actual=%0b/%0d expected=0/0", dropped_r0, count); end
        cycle();
        driveMem(3'd0, 16'h2222);
        driveAlu(3'd0, 16'h3333);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL r0_both actual=%0b/%0d expected=1/0", dropped_r0, count); end
        cycle();
        @(negedge clk);
        checks++; if (dropped_r0 !== 1'b0) begin errors++; $display("FAIL r0_both_end actual=%0b expected=0", dropped_r0); end
        cycle();
    endtask

    task automatic test_forward();
        hold = 1'b1;
        driveAlu(3'd4, 16'h0011);
        cycle();
        driveAlu(3'd4, 16'h0022);
        cycle();
        clearInputs();
        chk_num1 = 3'd4;
        chk_num2 = 3'd6;
        @(negedge clk);
        checks++; if (chk_hit1 !== 1'b1 || chk_data1 !== 16'h0022) begin errors++; $display("FAIL fwd_youngest actual=%0b/%0h expected=1/0022", chk_hit1, chk_data1); end
        checks++; if (chk_hit2 !== 1'b0 || chk_data2 !== 16'h0) begin errors++; $display("FAIL fwd_miss actual=%0b/%0h expected=0/0", chk_hit2, chk_data2); end
        chk_num1 = 3'd0;
        #1;
        checks++; if (chk_hit1 !== 1'b0 || chk_data1 !== 16'h0) begin errors++; $display("FAIL fwd_r0 actual=%0b/%0h expected=0/0", chk_hit1, chk_data1); end
        chk_num1 = 3'd4;
        driveMem(3'd6, 16'h0066);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fwd_count3 actual=%0d expected=3", count); end
        checks++; if (chk_hit2 !== 1'b1 || chk_data2 !== 16'h0066) begin errors++; $display("FAIL fwd_hit2 actual=%0b/%0h expected=1/0066", chk_hit2, chk_data2); end
        bus.mem_valid = 1'b1;
        bus.mem_num = 3'd7;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL ready_pair3 actual=%0b/%0b expected=1/0", bus.mem_ready, bus.alu_ready); end
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL ready_alu3 actual=%0b expected=1", bus.alu_ready); end
    endtask

    task automatic test_reset_mid();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count actual=%0d expected=0", count); end
        checks++; if (chk_hit2 !== 1'b0 || chk_hit1 !== 1'b0) begin errors++; $display("FAIL mid_reset_fwd actual=%0b/%0b expected=0/0", chk_hit1, chk_hit2); end
        hold = 1'b0;
        #1;
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL mid_reset_we actual=%0b expected=0", bus.regWrite); end
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (count !== 3'd0 || bus.regWrite !== 1'b0) begin errors++; $display("FAIL post_reset actual=%0d/%0b expected=0/0", count, bus.regWrite); end
        cycle();
        @(negedge clk);
        checks++; if (bus.regWrite !== 1'b0) begin errors++; $display("FAIL post_reset_stale actual=%0b expected=0", bus.regWrite); end
        cycle();
        driveAlu(3'd7, 16'h7777);
        cycle();
        clearInputs();
        @(negedge clk);
        checks++; if (bus.regWrite !== 1'b1 || bus.regWriteNum !== 3'd7 || bus.writeData !== 16'h7777) begin errors++; $display("FAIL post_reset_write actual=%0b/%0d/%0h expected=1/7/7777", bus.regWrite, bus.regWriteNum, bus.writeData); end
        cycle();
        @(negedge clk);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_reset_drain actual=%0d expected=0", count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_dual();
        test_full_hold();
        test_r0();
        test_forward();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
